// File: rtl/dot_product_engine.sv
// Pipelined N-element dot-product engine with a registered adder tree and multi-beat group accumulation.
// Weights are held in a register and can be bypassed on load. Signed/unsigned mode travels with each beat.
module dot_product_engine #(
    parameter int unsigned N        = 32,
    parameter int unsigned DW       = 4,
    parameter int unsigned ACC_BITS = 4,
    localparam int unsigned L       = $clog2(N),
    localparam int unsigned OW      = 2*DW + L + ACC_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            weight_valid,
    input  logic [N*DW-1:0] W,
    input  logic            signed_mode,
    input  logic            in_valid,
    input  logic            in_last,
    input  logic [N*DW-1:0] I,
    output logic            out_valid,
    output logic [OW-1:0]   OUT
);

    localparam int unsigned TW = 2*DW + L;

    logic [N*DW-1:0] w_q;
    logic            mode_q;
    logic [N*DW-1:0] w_sel;
    logic            mode_sel;
    logic [OW-1:0]   acc;
    logic [OW-1:0]   tree_ext;
    logic [OW-1:0]   acc_sum;

    // Element product, with both operands extended to 2*DW according to the beat's mode
    function automatic logic [2*DW-1:0] mul_elem(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b,
                                                 input logic          s);
        logic [2*DW-1:0] ea;
        logic [2*DW-1:0] eb;
        ea = s ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
        eb = s ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
        return ea * eb;
    endfunction

    // Weight register; survives clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q    <= '0;
            mode_q <= 1'b0;
        end else if (weight_valid) begin
            w_q    <= W;
            mode_q <= signed_mode;
        end
    end

    // A beat presented together with a weight load uses the new weights
    always_comb begin
        w_sel    = w_q;
        mode_sel = mode_q;
        if (weight_valid) begin
            w_sel    = W;
            mode_sel = signed_mode;
        end
    end

    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int unsigned CW  = 2*DW + l;
        localparam int unsigned CNT = N >> l;

        logic [CW-1:0] sum [CNT];
        logic          v;
        logic          lst;
        logic          md;

        if (l == 0) begin : g_prod
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v   <= 1'b0;
                    lst <= 1'b0;
                    md  <= 1'b0;
                    for (int i = 0; i < int'(CNT); i++) sum[i] <= '0;
                end else begin
                    v   <= in_valid & ~clear;
                    lst <= in_last;
                    md  <= mode_sel;
                    for (int i = 0; i < int'(CNT); i++)
                        sum[i] <= mul_elem(I[(int'(N)-i)*int'(DW)-1 -: DW],
                                           w_sel[(int'(N)-i)*int'(DW)-1 -: DW], mode_sel);
                end
            end
        end else begin : g_add
            logic [CW-2:0] prv [2*CNT];
            logic          prv_v;
            logic          prv_lst;
            logic          prv_md;

            always_comb begin
                prv     = g_lvl[l-1].sum;
                prv_v   = g_lvl[l-1].v;
                prv_lst = g_lvl[l-1].lst;
                prv_md  = g_lvl[l-1].md;
            end

            // Each level widens by one bit, extended per the beat's own mode
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v   <= 1'b0;
                    lst <= 1'b0;
                    md  <= 1'b0;
                    for (int i = 0; i < int'(CNT); i++) sum[i] <= '0;
                end else begin
                    v   <= prv_v & ~clear;
                    lst <= prv_lst;
                    md  <= prv_md;
                    for (int i = 0; i < int'(CNT); i++)
                        sum[i] <= {prv_md & prv[2*i][CW-2],   prv[2*i]} +
                                  {prv_md & prv[2*i+1][CW-2], prv[2*i+1]};
                end
            end
        end
    end

    always_comb begin
        tree_ext = {{ACC_BITS{g_lvl[L].md & g_lvl[L].sum[0][TW-1]}}, g_lvl[L].sum[0]};
        acc_sum  = acc + tree_ext;
    end

    // Group accumulation, wraps modulo 2^OW; OUT is zero whenever out_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            OUT       <= '0;
        end else if (clear) begin
            acc       <= '0;
            out_valid <= 1'b0;
            OUT       <= '0;
        end else begin
            out_valid <= 1'b0;
            OUT       <= '0;
            if (g_lvl[L].v) begin
                if (g_lvl[L].lst) begin
                    OUT       <= acc_sum;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: doc/dot_product_engine.md
# dot_product_engine

Parametrised, fully pipelined dot-product engine. Each accepted beat multiplies an N-element input vector element-wise by a stored N-element weight vector and reduces the products through a registered adder tree. Consecutive beats are accumulated until a beat tagged `in_last`, and the group total is then emitted. It is the multi-beat, signed-capable successor to the fixed 32×4-bit single-shot MAC used in the serial-input datapath. It accepts one beat per clock with no bubbles.

## Interface

- `N`, 32: elements per beat; power of two, ≥2. `L = clog2(N)`.
- `DW`, 4: element width of I and W.
- `ACC_BITS`, 4: accumulation headroom bits.
- `OW`, derived = `2*DW + L + ACC_BITS` (17 at defaults): output width.
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `clear`, in, 1: synchronous flush of pipeline and accumulator.
- `weight_valid`, in, 1: load W and signed_mode this cycle.
- `W`, in, N*DW: weights; element 0 at `W[N*DW-1 -: DW]`, element N-1 at LSBs.
- `signed_mode`, in, 1: 1 = two's-complement elements, 0 = unsigned; latched with weight_valid.
- `in_valid`, in, 1: I beat valid.
- `in_last`, in, 1: qualifies in_valid; closes the accumulation group.
- `I`, in, N*DW: input vector; same packing as W.
- `out_valid`, out, 1: OUT valid, single-cycle pulse.
- `OUT`, out, OW: group result; two's complement when signed.

## Operation

- Weight register holds W and mode until the next weight_valid. Reset value is all zero, unsigned.
- weight_valid and in_valid in the same cycle: the beat uses the newly presented W and signed_mode (bypass). The register also loads.
- Stage P: N products of width 2*DW, signed or unsigned per mode, tagged with valid, last, and mode.
- Stages T1..TL: pairwise tree. Level l sums adjacent pairs from level l-1 and is 2*DW+l bits wide. Each level is sign-extended in signed mode and zero-extended otherwise.
- Accumulate/output stage, when a tree result is valid:
  - Not last: `acc <= acc + ext(tree)`.
  - Last: `OUT <= acc + ext(tree)`, `out_valid <= 1`, `acc <= 0`.
- Accumulator arithmetic is modulo 2^OW (wrap, no saturation). Groups longer than 2^ACC_BITS beats may wrap; this is not flagged.
- A group may start on the cycle after a last beat. The accumulator is already 0 and no bubble is inserted.
- Mode is carried per beat. Mixing modes inside one group is legal; each beat is extended with its own mode.
- `in_last` without `in_valid` is ignored.
- `clear`:
  - Zeroes all pipeline valid bits and the accumulator, and forces out_valid=0 and OUT=0 next edge.
  - The weight register is preserved.
  - If clear and in_valid coincide, the beat is dropped.
- When out_valid=0, OUT is held at 0.

## Timing

- Reset: out_valid=0, OUT=0, acc=0, all pipeline valids 0, weights 0, mode unsigned.
- Reset mid-operation discards every in-flight beat and the partial group. No output appears.
- Latency: a beat sampled at edge k reaches P at k, TL at k+L, and OUT at k+L+1. At defaults, out_valid is high in the cycle after edge k+6.
- Throughput: 1 beat per cycle. There is no backpressure; the consumer must take out_valid when it pulses.
- weight_valid at edge k affects beats sampled at edge ≥k. Beats already in flight keep their products.
- A single-beat group (in_valid & in_last) gives out_valid L+1 edges later.

## Test plan

- Defaults, unsigned. W=all 0xF, single beat I=all 0xF with last at edge k -> out_valid only after edge k+6, OUT=7200.
- Signed. W=all 0x8, I=all 0x8, last -> OUT=2048. W=all 0x7, I=all 0xF -> OUT=-224 (0x1FF20).
- Accumulation, unsigned all-0xF:
  - 16 back-to-back beats with last on the 16th -> one pulse, OUT=115200.
  - 19 beats -> OUT=5728 (wrap).
  - The next group starts immediately and its result is uncorrupted.
- Weight bypass. weight_valid with W=all 0x1 coincident with a last beat of I=all 0x3, prior W=all 0x2 -> OUT=96. Previous in-flight beat still uses W=0x2.
- clear:
  - Asserted two cycles into a 4-beat group -> no out_valid for that group.
  - The following single beat with I=W=all 0x1 -> OUT=32.
- rst_n pulsed low mid-group -> all outputs 0 immediately. Weights read 0, so a following beat with unchanged W gives OUT=0.
